// File: rtl/hough_sync_fifo_if.sv
// Handshake/status bundle for hough_sync_fifo.
// The hwm signal exists only when HOUGH_FIFO_HWM_EN is defined.
interface hough_sync_fifo_if #(
    parameter int DATA_WIDTH = 21,
    parameter int DEPTH      = 16384
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;
`ifdef HOUGH_FIFO_HWM_EN
    logic [ADDR_WIDTH:0]   hwm;

    modport master (
        output wr_data, wr_en, rd_en, err_clr,
        input  full, almost_full, rd_data, empty, almost_empty, count,
               overflow, underflow, hwm
    );
    modport slave (
        input  wr_data, wr_en, rd_en, err_clr,
        output full, almost_full, rd_data, empty, almost_empty, count,
               overflow, underflow, hwm
    );
`else
    modport master (
        output wr_data, wr_en, rd_en, err_clr,
        input  full, almost_full, rd_data, empty, almost_empty, count,
               overflow, underflow
    );
    modport slave (
        input  wr_data, wr_en, rd_en, err_clr,
        output full, almost_full, rd_data, empty, almost_empty, count,
               overflow, underflow
    );
`endif
endinterface

// File: rtl/hough_sync_fifo.sv
// Single-clock FIFO between the Hough pixel-scan front end and the accumulator.
// Optional high-water mark register enabled by defining HOUGH_FIFO_HWM_EN.
module hough_sync_fifo #(
    parameter int DATA_WIDTH    = 21,
    parameter int DEPTH         = 16384,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int ADDR_WIDTH    = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               resetn,
    hough_sync_fifo_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LP_AFULL   = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   LP_AEMPTY  = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LP_CNT_0   = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR_0   = ADDR_WIDTH'(0);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_afull;
    logic                  r_empty;
    logic                  r_aempty;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_to_out;
    logic                  w_mem_wr;
    logic                  w_mem_rd;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Accept decode; in FWFT mode the output register is the head slot, so a
    // write into an otherwise empty head bypasses the memory.
    always_comb begin
        w_wr_acc = bus.wr_en & ~r_full;
        w_rd_acc = bus.rd_en & ~r_empty;
        w_to_out = 1'b0;
        w_mem_rd = w_rd_acc;
        if (FWFT != 0) begin
            w_to_out = w_wr_acc & (r_empty | (w_rd_acc & (r_count == LP_CNT_ONE)));
            w_mem_rd = w_rd_acc & (r_count > LP_CNT_ONE);
        end else begin
            w_to_out = 1'b0;
            w_mem_rd = w_rd_acc;
        end
        w_mem_wr = w_wr_acc & ~w_to_out;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + LP_CNT_ONE;
            2'b01:   w_count_nxt = r_count - LP_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (resetn && w_mem_wr) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and flags registered from the next count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= LP_PTR_0;
            r_rd_ptr <= LP_PTR_0;
            r_count  <= LP_CNT_0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else begin
            if (w_mem_wr) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            if (w_mem_rd) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == LP_DEPTH);
            r_afull  <= (w_count_nxt >= LP_AFULL);
            r_empty  <= (w_count_nxt == LP_CNT_0);
            r_aempty <= (w_count_nxt <= LP_AEMPTY);
        end
    end

    // Read data register; holds when nothing is loaded (stable while empty in FWFT).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_data <= {DATA_WIDTH{1'b0}};
        end else if (FWFT != 0) begin
            if (w_mem_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end else if (w_to_out) begin
                r_rd_data <= bus.wr_data;
            end
        end else if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (bus.wr_en & r_full)  | (r_ovf & ~bus.err_clr);
            r_udf <= (bus.rd_en & r_empty) | (r_udf & ~bus.err_clr);
        end
    end

`ifdef HOUGH_FIFO_HWM_EN
    logic [ADDR_WIDTH:0] r_hwm;

    // High-water mark follows registered count, so it trails count by a cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hwm <= LP_CNT_0;
        end else if (bus.err_clr) begin
            r_hwm <= r_count;
        end else if (r_count > r_hwm) begin
            r_hwm <= r_count;
        end
    end

    assign bus.hwm = r_hwm;
`endif

    assign bus.full         = r_full;
    assign bus.almost_full  = r_afull;
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_aempty;
    assign bus.count        = r_count;
    assign bus.rd_data      = r_rd_data;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;

endmodule

// File: doc/hough_sync_fifo.md
# hough_sync_fifo

Parametrised single-clock FIFO for the Hough-transform datapath. It buffers edge-point and vote words between the pixel-scan front end and the accumulator stage. It provides selectable standard or first-word-fall-through read mode, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 21, word width in bits
- DEPTH, 16384, capacity in words; power of two, >= 4
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-4, almost_full asserts when count >= this value
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value
- ADDR_WIDTH, $clog2(DEPTH), derived; do not override

- clk  in  1  clock; all logic is on the rising edge
- resetn  in  1  reset, synchronous, active-low
- wr_data  in  DATA_WIDTH  write word
- wr_en  in  1  write request
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AFULL_THRESH
- rd_en  in  1  read request (pop)
- rd_data  out  DATA_WIDTH  read word (see Operation)
- empty  out  1  count == 0
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  words currently held
- err_clr  in  1  clears overflow, underflow (and hwm when enabled)
- overflow  out  1  sticky; a write was rejected
- underflow  out  1  sticky; a read was rejected
- hwm  out  ADDR_WIDTH+1  high-water mark; present only with HOUGH_FIFO_HWM_EN

## Operation
- Write accept: wr_acc = wr_en & !full. Read accept: rd_acc = rd_en & !empty. Both use registered flags.
- A write while full is dropped, even if a read is accepted in the same cycle. It sets overflow.
- A read while empty is ignored and sets underflow. On empty, a simultaneous write is still accepted.
- count: increments on wr_acc only, decrements on rd_acc only, and is unchanged when both or neither occur.
- Pointers wrap modulo DEPTH. Total capacity is exactly DEPTH words in both modes.
- Standard mode (FWFT=0):
  - rd_data loads the head word on the edge where rd_acc is high.
  - It holds its value otherwise.
- FWFT mode (FWFT=1):
  - rd_data is an output register that always holds the head word while empty=0.
  - rd_acc pops that word. The next word (or a word written into an empty FIFO) is loaded on the same edge.
  - The output register counts toward count.
  - rd_data value while empty=1 is don't-care but stable.
- All status outputs are decoded from registered count and flag state. There is no combinational path from any input to any output.
- Sticky flags:
  - Set by the error event.
  - Cleared by err_clr.
  - If err_clr and a new error occur in the same cycle, the flag stays set.
- Memory contents are not reset.

## Timing
- Reset values: full 0, almost_full 0, empty 1, almost_empty 1, count 0, rd_data 0, overflow 0, underflow 0, hwm 0. Pointers are also reset to 0.
- Reset asserted mid-operation discards all held words on the next edge. The first write after release lands at address 0.
- Write-to-empty-deassert latency: empty falls 1 cycle after the wr_acc edge, in both modes.
- Standard read latency: rd_data is valid 1 cycle after the rd_acc edge.
- FWFT read latency: rd_data is valid in the same cycle that empty=0. Back-to-back rd_en sustains 1 word/cycle.
- Flags and count update on the edge following the accepting cycle. full and empty are never both 1.
- Throughput: 1 write and 1 read per cycle sustained when neither full nor empty.

## Configuration
- HOUGH_FIFO_HWM_EN defined:
  - Adds the hwm port and a register tracking the maximum count value since reset or the last err_clr.
  - hwm updates 1 cycle after count rises above it.
  - On err_clr, hwm loads the current count.
- Undefined: the hwm port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then write 5 words 0x00001..0x00005 with no reads -> count=5, empty=0, almost_empty=0 (AEMPTY_THRESH=4). Standard reads return 0x00001..0x00005, each 1 cycle after rd_en.
- DEPTH=16: write 17 words -> full=1 after the 16th, 17th dropped, overflow=1, count=16. err_clr -> overflow=0.
- FWFT=1: write 0x1ABCD into an empty FIFO -> next cycle empty=0 and rd_data=0x1ABCD with no rd_en. Pulse rd_en -> empty=1, count=0.
- DEPTH=16, full: assert wr_en and rd_en together -> read accepted, write dropped, count=15, overflow=1. Empty: both asserted -> count=1, underflow=1.
- Write/read 3×DEPTH words continuously (pointer wrap) -> data order preserved, count is constant 1 in steady state. Assert resetn=0 mid-stream -> next cycle count=0, empty=1, rd_data=0.
- With HOUGH_FIFO_HWM_EN: fill to 12, drain to 2 -> hwm=12. err_clr -> hwm=2.
